// File: rtl/fifo0_enq_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo0_enq_arbiter_pkg : shared FSM encoding and stats helpers              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo0_enq_arbiter_pkg;

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_DRAIN = 2'd1;
  localparam logic [1:0] c_ST_CLEAR = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  localparam int c_STAT_W = 16;

  function automatic logic [c_STAT_W-1:0] sat_inc(input logic [c_STAT_W-1:0] v);
    return (v == {c_STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo0_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo0_rr_pick : combinational circular priority encoder from i_ptr        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo0_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_vld
);

  logic [PTR_W-1:0] w_scan;

  // Walk NREQ positions starting at i_ptr, wrapping by compare so non-power-of-two NREQ works.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_scan = i_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_vld && i_en && i_req[w_scan]) begin
        o_vld         = 1'b1;
        o_idx         = w_scan;
        o_gnt[w_scan] = 1'b1;
      end
      w_scan = (w_scan == PTR_W'(NREQ-1)) ? '0 : w_scan + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo0_enq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo0_enq_arbiter : round-robin enqueue arbiter and flush sequencer for a  |
// | data-less token FIFO. Optional grant counters under FIFO0_ARB_STATS_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo0_enq_arbiter
  import fifo0_enq_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DRAIN_TMO = 15,
  parameter int TMO_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_fifo_enq,
  output logic            o_fifo_clr,
  input  logic            i_fifo_full_n,
  input  logic            i_fifo_empty_n,
  input  logic            i_flush_req,
  output logic            o_flush_done,
  output logic            o_flush_tmo,
  output logic            o_busy
`ifdef FIFO0_ARB_STATS_EN
  ,
  output logic [NREQ*c_STAT_W-1:0] o_gnt_cnt
`endif
);

  localparam int c_PTR_W = $clog2(NREQ);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [TMO_WIDTH-1:0] r_tmo;
  logic                 r_timed_out;
  logic                 r_fifo_clr;
  logic                 r_flush_done;
  logic                 r_flush_tmo;
  logic                 w_tmo_hit;
  logic                 w_pick_en;
  logic                 w_any;
  logic [c_PTR_W-1:0]   w_idx;

  assign w_pick_en = (r_state == c_ST_RUN) && i_fifo_full_n && !rst;
  assign w_tmo_hit = (r_tmo == TMO_WIDTH'(DRAIN_TMO-1));

  fifo0_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_PTR_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .i_en  (w_pick_en),
    .o_gnt (o_gnt),
    .o_idx (w_idx),
    .o_vld (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:   if (i_flush_req) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (!i_fifo_empty_n || w_tmo_hit) w_state_nxt = c_ST_CLEAR;
      c_ST_CLEAR: w_state_nxt = c_ST_DONE;
      default:    w_state_nxt = c_ST_RUN;
    endcase
  end

  // Pulse outputs are flopped from the next state so they align with CLEAR/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_RUN;
      r_ptr        <= '0;
      r_tmo        <= '0;
      r_timed_out  <= 1'b0;
      r_fifo_clr   <= 1'b0;
      r_flush_done <= 1'b0;
      r_flush_tmo  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fifo_clr   <= (w_state_nxt == c_ST_CLEAR);
      r_flush_done <= (w_state_nxt == c_ST_DONE);
      r_flush_tmo  <= (w_state_nxt == c_ST_DONE) && r_timed_out;

      if (r_state == c_ST_DRAIN && w_state_nxt == c_ST_DRAIN)
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;

      if (r_state == c_ST_DRAIN && i_fifo_empty_n && w_tmo_hit)
        r_timed_out <= 1'b1;
      else if (r_state == c_ST_DONE)
        r_timed_out <= 1'b0;

      if (r_state == c_ST_CLEAR)
        r_ptr <= '0;
      else if (w_any)
        r_ptr <= (w_idx == c_PTR_W'(NREQ-1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_fifo_enq   = |o_gnt;
  assign o_fifo_clr   = r_fifo_clr;
  assign o_flush_done = r_flush_done;
  assign o_flush_tmo  = r_flush_tmo;
  assign o_busy       = (r_state != c_ST_RUN);

`ifdef FIFO0_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [c_STAT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst || r_state == c_ST_CLEAR)
        r_cnt <= '0;
      else if (o_gnt[gi])
        r_cnt <= sat_inc(r_cnt);
    end
    assign o_gnt_cnt[gi*c_STAT_W +: c_STAT_W] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo0_enq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo0_enq_arbiter : scoreboard bench with a behavioural arbiter model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo0_enq_arbiter;

  localparam int NREQ      = 4;
  localparam int DRAIN_TMO = 15;
  localparam int TMO_WIDTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '1;
  logic            full_n = 1'b1;
  logic            empty_n = 1'b0;
  logic            flush = 1'b0;
  logic [NREQ-1:0] gnt;
  logic            enq, clr, done, tmo, busy;
`ifdef FIFO0_ARB_STATS_EN
  logic [NREQ*16-1:0] gnt_cnt;
`endif

  always #5 clk = ~clk;

  fifo0_enq_arbiter #(
    .NREQ      (NREQ),
    .DRAIN_TMO (DRAIN_TMO),
    .TMO_WIDTH (TMO_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (req),
    .o_gnt          (gnt),
    .o_fifo_enq     (enq),
    .o_fifo_clr     (clr),
    .i_fifo_full_n  (full_n),
    .i_fifo_empty_n (empty_n),
    .i_flush_req    (flush),
    .o_flush_done   (done),
    .o_flush_tmo    (tmo),
    .o_busy         (busy)
`ifdef FIFO0_ARB_STATS_EN
    ,
    .o_gnt_cnt      (gnt_cnt)
`endif
  );

  typedef struct packed {
    logic [NREQ-1:0]    gnt;
    logic               enq;
    logic               clr;
    logic               done;
    logic               tmo;
    logic               busy;
    logic [NREQ*16-1:0] cnt;
  } exp_t;

  typedef enum int {M_RUN, M_DRAIN, M_CLEAR, M_DONE} mode_t;

  exp_t  sb[$];
  exp_t  mx;
  int    n_cmp = 0;
  int    n_err = 0;

  mode_t m_mode = M_RUN;
  int    m_ptr = 0;
  int    m_wait = 0;
  bit    m_to = 1'b0;
  int    m_stat[NREQ];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  // Drive one cycle, record the model's expected outputs, then advance the model.
  task automatic cycle(input bit r, input logic [NREQ-1:0] q, input bit f, input bit e, input bit fl);
    exp_t x;
    int   gi;
    @(posedge clk);
    #1;
    rst = r; req = q; full_n = f; empty_n = e; flush = fl;
    gi = -1;
    if (!r && m_mode == M_RUN && f) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && q[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      end
    end
    x.gnt  = (gi >= 0) ? NREQ'(1 << gi) : '0;
    x.enq  = (gi >= 0);
    x.clr  = (m_mode == M_CLEAR);
    x.done = (m_mode == M_DONE);
    x.tmo  = (m_mode == M_DONE) && m_to;
    x.busy = (m_mode != M_RUN);
    for (int i = 0; i < NREQ; i++) x.cnt[i*16 +: 16] = 16'(m_stat[i]);
    sb.push_back(x);

    if (r) begin
      m_mode = M_RUN; m_ptr = 0; m_wait = 0; m_to = 1'b0;
      for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    end else begin
      if (gi >= 0 && m_stat[gi] < 65535) m_stat[gi]++;
      case (m_mode)
        M_RUN: begin
          if (gi >= 0) m_ptr = (gi + 1) % NREQ;
          if (fl) begin m_mode = M_DRAIN; m_wait = 0; end
        end
        M_DRAIN: begin
          m_wait++;
          if (!e) m_mode = M_CLEAR;
          else if (m_wait == DRAIN_TMO) begin m_mode = M_CLEAR; m_to = 1'b1; end
        end
        M_CLEAR: begin
          m_mode = M_DONE; m_ptr = 0;
          for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
        end
        default: begin m_mode = M_RUN; m_to = 1'b0; end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      chk("gnt",        longint'(gnt),  longint'(mx.gnt));
      chk("fifo_enq",   longint'(enq),  longint'(mx.enq));
      chk("fifo_clr",   longint'(clr),  longint'(mx.clr));
      chk("flush_done", longint'(done), longint'(mx.done));
      chk("flush_tmo",  longint'(tmo),  longint'(mx.tmo));
      chk("busy",       longint'(busy), longint'(mx.busy));
`ifdef FIFO0_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
        chk("gnt_cnt", longint'(gnt_cnt[i*16 +: 16]), longint'(mx.cnt[i*16 +: 16]));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    // Second reset cycle, then round robin with all requesters active.
    cycle(1, 4'b1111, 1, 0, 0);
    for (int n = 0; n < 9; n++) cycle(0, 4'b1111, 1, 0, 0);
    // Sparse requests, then a full FIFO holding off grants.
    cycle(0, 4'b1010, 1, 0, 0);
    cycle(0, 4'b1010, 1, 0, 0);
    for (int n = 0; n < 3; n++) cycle(0, 4'b1010, 0, 0, 0);
    cycle(0, 4'b1010, 1, 0, 0);
    // Flush of an empty FIFO, grant issued alongside the request.
    cycle(0, 4'b0100, 1, 0, 1);
    for (int n = 0; n < 4; n++) cycle(0, 4'b1111, 1, 0, 0);
    // Flush that times out.
    cycle(0, 4'b0000, 1, 1, 1);
    for (int n = 0; n < 19; n++) cycle(0, 4'b1111, 1, 1, 0);
    // Reset in the middle of a drain.
    cycle(0, 4'b0010, 1, 1, 1);
    for (int n = 0; n < 3; n++) cycle(0, 4'b1111, 1, 1, 0);
    cycle(1, 4'b1111, 1, 1, 0);
    for (int n = 0; n < 4; n++) cycle(0, 4'b1111, 1, 1, 0);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++)
      cycle(($urandom % 97) == 0, NREQ'($urandom), ($urandom % 5) != 0,
            ($urandom % 12) != 0, ($urandom % 20) == 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
